// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO.
// Define MMIO_UART_IRQ_EN to build the registered TX-empty interrupt and CTRL.irq_en.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        m_rnw,
    input  logic        m_sel,
    output logic [31:0] s_data,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   div, div_eff, reload, reload_n, timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          ovf, enable, irq_en;
    logic          wr, rd, ctrl_wr, push_req, push, pop, flush, clr_ovf;
    logic          empty, full, busy, last;
    logic          unused;

    assign wr       = m_sel & ~m_rnw;
    assign rd       = m_sel & m_rnw;
    assign ctrl_wr  = wr & (m_addr[3:2] == 2'd3);
    assign push_req = wr & (m_addr[3:2] == 2'd0);
    assign flush    = ctrl_wr & m_data[2];
    assign clr_ovf  = ctrl_wr & m_data[3];
    assign empty    = count == '0;
    assign full     = count == FULL_CNT;
    assign push     = push_req & ~full & ~flush;
    assign busy     = state != IDLE;
    assign last     = timer == '0;
    assign div_eff  = (div == '0) ? 16'd1 : div;
    assign tx       = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
    assign unused   = ^{m_addr[31:4], m_addr[1:0], m_data[31:16]};

    assign s_data = !rd ? '0 :
                    (m_addr[3:2] == 2'd1) ? {16'd0, 8'(count), 4'd0, ovf, full, empty, busy} :
                    (m_addr[3:2] == 2'd2) ? {16'd0, div} :
                    (m_addr[3:2] == 2'd3) ? {30'd0, irq_en, enable} : '0;

    // The bit timer reloads from the divisor latched at frame start, so DIV writes
    // mid-frame only affect the next frame.
    always_comb begin
        state_n   = state;
        timer_n   = last ? reload - 16'd1 : timer - 16'd1;
        reload_n  = reload;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        pop       = 1'b0;
        if (state == IDLE || (state == STOP && last)) begin
            if (enable && !empty) begin
                pop      = 1'b1;
                state_n  = START;
                timer_n  = div_eff - 16'd1;
                reload_n = div_eff;
                shreg_n  = mem[rd_ptr];
            end else if (state == STOP) begin
                state_n = IDLE;
            end
        end else if (state == START && last) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
        end else if (state == DATA && last) begin
            shreg_n   = shreg >> 1;
            bit_idx_n = bit_idx + 3'd1;
            state_n   = (bit_idx == 3'd7) ? STOP : DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            reload  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            reload  <= reload_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= DIV_RESET;
            enable <= 1'b0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
            rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
            count  <= flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
            ovf    <= (push_req & full) | (ovf & ~clr_ovf);
            if (wr && m_addr[3:2] == 2'd2)
                div <= m_data[15:0];
            if (ctrl_wr)
                enable <= m_data[0];
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= m_data[7:0];

`ifdef MMIO_UART_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en <= m_data[1];
            irq <= irq_en & empty & ~busy;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif
endmodule
